imem_loader_server: RTL and testbench

- Instruction-side counterpart to the single-cycle Mips_machine core.
- The core reads InstMem_Out from PCOut; this block writes and serves that memory.
- Accepts a program as a valid/ready word stream and stores it in internal instruction RAM. Holds the core in reset while loading.
- Then releases the core and answers every PC with the instruction word, combinationally in the same cycle, as the single-cycle datapath needs.
- Sits between the testbench/boot source and the core's InstMem_Out, PCOut and rst pins.

---
 rtl/imem_loader_server.sv | 169 ++++++++++++++++
 tb/tb_imem_loader_server.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_server.sv
// Instruction memory for the single-cycle Mips_machine core: loads a program from a
// valid/ready stream while holding the core in reset, then serves InstMem_Out combinationally.
module imem_loader_server #(
  parameter int          DEPTH    = 256,
  parameter int          AW       = 8,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          REL_CYC  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  input  logic          reload,
  input  logic [31:0]   pc_in,
  output logic [31:0]   inst_out,
  output logic          core_rst,
  output logic [AW:0]   prog_len,
  output logic          run,
  output logic          addr_err
);

  localparam int              RCW      = (REL_CYC > 1) ? $clog2(REL_CYC) : 1;
  localparam logic [AW:0]     LEN_ONE  = (AW+1)'(1);
  localparam logic [AW:0]     LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [RCW-1:0]  REL_LAST = RCW'(REL_CYC - 1);
  localparam logic [RCW-1:0]  REL_ONE  = RCW'(1);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     prog_len_q, prog_len_d;
  logic [RCW-1:0]  rel_cnt_q, rel_cnt_d;
  logic            addr_err_q, addr_err_d;
  logic            core_rst_q, core_rst_d;
  logic            load_ready_q, load_ready_d;
  logic            run_q, run_d;
  logic            wr_en_s;
  logic            pc_in_range_s;
  logic [31:0]     mem [DEPTH];

  // Full 32-bit compare so high PC bits can never alias into the stored program.
  assign pc_in_range_s = (pc_in < {{(31-AW){1'b0}}, prog_len_q});

  // Next-state, load pointer, release counter and sticky fetch-error logic.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    rel_cnt_d  = rel_cnt_q;
    addr_err_d = addr_err_q;
    wr_en_s    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (load_valid && load_ready_q) begin
          wr_en_s    = 1'b1;
          wr_ptr_d   = wr_ptr_q + PTR_ONE;
          prog_len_d = prog_len_q + LEN_ONE;
          if (load_last || (prog_len_q == (LEN_FULL - LEN_ONE))) begin
            state_d   = ST_RELEASE;
            rel_cnt_d = '0;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RELEASE: begin
        if (rel_cnt_q == REL_LAST) begin
          state_d   = ST_RUN;
          rel_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + REL_ONE;
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_d    = ST_LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
          addr_err_d = 1'b0;
        end else if (!pc_in_range_s) begin
          addr_err_d = 1'b1;
        end else begin
          addr_err_d = addr_err_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Handshake and core-reset outputs are registered from the next state.
  always_comb begin
    core_rst_d   = 1'b1;
    load_ready_d = 1'b0;
    run_d        = 1'b0;
    case (state_d)
      ST_LOAD: begin
        load_ready_d = 1'b1;
      end
      ST_RELEASE: begin
        load_ready_d = 1'b0;
      end
      ST_RUN: begin
        core_rst_d = 1'b0;
        run_d      = 1'b1;
      end
      default: begin
        load_ready_d = 1'b1;
      end
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      rel_cnt_q    <= '0;
      addr_err_q   <= 1'b0;
      core_rst_q   <= 1'b1;
      load_ready_q <= 1'b1;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      rel_cnt_q    <= rel_cnt_d;
      addr_err_q   <= addr_err_d;
      core_rst_q   <= core_rst_d;
      load_ready_q <= load_ready_d;
      run_q        <= run_d;
    end
  end

  // Instruction RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_q] <= load_data;
    end
  end

  // Zero-latency fetch for the single-cycle datapath.
  always_comb begin
    if (run_q && pc_in_range_s) begin
      inst_out = mem[pc_in[AW-1:0]];
    end else begin
      inst_out = NOP_WORD;
    end
  end

  assign load_ready = load_ready_q;
  assign core_rst   = core_rst_q;
  assign prog_len   = prog_len_q;
  assign run        = run_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_imem_loader_server.sv
// Self-checking bench for imem_loader_server: fixed fetch tables plus randomized loads and
// fetches compared against a queue/array model of the loaded program.
module tb_imem_loader_server;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int          RELC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = 32'h0;
  logic        load_last = 1'b0;
  logic        reload = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] inst_out;
  logic        core_rst;
  logic [8:0]  prog_len;
  logic        run;
  logic        addr_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] prog  [256];
  logic [31:0] m_mem [256];
  logic [31:0] m_len = 32'd0;
  logic        m_err = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } vec_t;
  vec_t vt [8];

  imem_loader_server dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .reload(reload), .pc_in(pc_in),
    .inst_out(inst_out), .core_rst(core_rst), .prog_len(prog_len), .run(run),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams prog[0..n-1] with random gaps, then checks the release window and RUN entry.
  task automatic load_prog(input int n, input bit use_last);
    int i = 0;
    int cyc = 0;
    int idle = 0;
    while (i < n) begin
      load_valid = (idle >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
      load_data  = load_valid ? prog[i] : $urandom;
      load_last  = load_valid ? (use_last && (i == n - 1)) : 1'($urandom_range(0, 1));
      reload     = 1'($urandom_range(0, 1));
      pc_in      = $urandom_range(0, 3);
      #1;
      check("load_ready_in_load", 32'(load_ready), 32'd1);
      check("core_rst_in_load", 32'(core_rst), 32'd1);
      check("run_in_load", 32'(run), 32'd0);
      check("inst_nop_in_load", inst_out, NOP);
      check("prog_len_count", 32'(prog_len), 32'(i));
      tick();
      if (load_valid) begin
        i++;
        idle = 0;
      end else begin
        idle++;
      end
      cyc++;
      if (cyc > 10 * n + 20) begin
        total++;
        bad++;
        $display("FAIL load_timeout: got %0d handshakes want %0d", i, n);
        break;
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    pc_in      = 32'd0;
    for (int k = 0; k < RELC; k++) begin
      reload = 1'($urandom_range(0, 1));
      #1;
      check("load_ready_release", 32'(load_ready), 32'd0);
      check("core_rst_release", 32'(core_rst), 32'd1);
      check("run_release", 32'(run), 32'd0);
      check("inst_nop_release", inst_out, NOP);
      check("prog_len_release", 32'(prog_len), 32'(n));
      tick();
    end
    reload = 1'b0;
    #1;
    check("run_entered", 32'(run), 32'd1);
    check("core_rst_released", 32'(core_rst), 32'd0);
    check("load_ready_run", 32'(load_ready), 32'd0);
    for (int k = 0; k < n; k++) m_mem[k] = prog[k];
    m_len = 32'(n);
    m_err = 1'b0;
  endtask

  task automatic run_rand(input int cycles);
    logic [31:0] pc;
    logic [31:0] exp;
    for (int c = 0; c < cycles; c++) begin
      case ($urandom_range(0, 3))
        0, 1:    pc = $urandom_range(0, m_len - 1);
        2:       pc = m_len + $urandom_range(0, 3);
        default: pc = $urandom;
      endcase
      pc_in = pc;
      #1;
      exp = (pc < m_len) ? m_mem[pc[7:0]] : NOP;
      check("rand_fetch", inst_out, exp);
      check("rand_addr_err", 32'(addr_err), 32'(m_err));
      tick();
      if (pc >= m_len) m_err = 1'b1;
    end
    pc_in = 32'd0;
    #1;
    check("rand_addr_err_end", 32'(addr_err), 32'(m_err));
  endtask

  task automatic run_vec(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      pc_in = vt[k].pc;
      #1;
      check("vec_fetch", inst_out, vt[k].inst);
      tick();
      check("vec_addr_err", 32'(addr_err), 32'(vt[k].err));
    end
    pc_in = 32'd0;
    m_err = vt[cnt-1].err;
  endtask

  task automatic pulse_reload();
    pc_in  = 32'd0;
    reload = 1'b1;
    #1;
    tick();
    reload = 1'b0;
    #1;
    check("reload_core_rst", 32'(core_rst), 32'd1);
    check("reload_run", 32'(run), 32'd0);
    check("reload_prog_len", 32'(prog_len), 32'd0);
    check("reload_addr_err", 32'(addr_err), 32'd0);
    check("reload_load_ready", 32'(load_ready), 32'd1);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_prog_len", 32'(prog_len), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_run", 32'(run), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_inst_out", inst_out, NOP);

    // Basic 4-word program and fixed fetch table.
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003;
    prog[2] = 32'h0022_1820; prog[3] = 32'h0800_0000;
    load_prog(4, 1'b1);
    vt[0] = '{32'd0,         32'h2001_0005, 1'b0};
    vt[1] = '{32'd1,         32'h2002_0003, 1'b0};
    vt[2] = '{32'd2,         32'h0022_1820, 1'b0};
    vt[3] = '{32'd3,         32'h0800_0000, 1'b0};
    vt[4] = '{32'd4,         NOP,           1'b1};
    vt[5] = '{32'h0000_0102, NOP,           1'b1};
    vt[6] = '{32'd2,         32'h0022_1820, 1'b1};
    vt[7] = '{32'hFFFF_FFFF, NOP,           1'b1};
    run_vec(8);

    // Reload with a 2-word program.
    pulse_reload();
    prog[0] = 32'hAAAA_0001; prog[1] = 32'hAAAA_0002;
    load_prog(2, 1'b1);
    vt[0] = '{32'd0, 32'hAAAA_0001, 1'b0};
    vt[1] = '{32'd1, 32'hAAAA_0002, 1'b0};
    vt[2] = '{32'd2, NOP,           1'b1};
    vt[3] = '{32'd3, NOP,           1'b1};
    run_vec(4);

    // Random program with backpressure gaps, random fetches.
    pulse_reload();
    for (int k = 0; k < 20; k++) prog[k] = $urandom;
    load_prog(20, 1'b1);
    run_rand(60);

    // Full memory without load_last.
    pulse_reload();
    for (int k = 0; k < 256; k++) prog[k] = $urandom;
    load_prog(256, 1'b0);
    vt[0] = '{32'd255,       prog[255], 1'b0};
    vt[1] = '{32'd0,         prog[0],   1'b0};
    vt[2] = '{32'h0000_0100, NOP,       1'b1};
    run_vec(3);
    run_rand(40);

    // Reset after 3 of 5 words, then a fresh 2-word load.
    pulse_reload();
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1;
      load_data  = 32'hBEEF_0000 + 32'(k);
      load_last  = 1'b0;
      #1;
      tick();
    end
    load_valid = 1'b0;
    #1;
    check("midload_prog_len", 32'(prog_len), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_prog_len", 32'(prog_len), 32'd0);
    check("midrst_core_rst", 32'(core_rst), 32'd1);
    check("midrst_load_ready", 32'(load_ready), 32'd1);
    check("midrst_run", 32'(run), 32'd0);
    prog[0] = 32'h1111_0001; prog[1] = 32'h1111_0002;
    load_prog(2, 1'b1);
    vt[0] = '{32'd0, 32'h1111_0001, 1'b0};
    vt[1] = '{32'd1, 32'h1111_0002, 1'b0};
    vt[2] = '{32'd2, NOP,           1'b1};
    run_vec(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
